snax_csr_mgr: RTL and testbench

- CSR manager in front of a SNAX accelerator's register block.
- Accepts core-side CSR read/write requests and keeps a shadow copy of the read/write (RW) register set.
- A write to the commit address (the last RW index) pushes the whole RW set to the accelerator over a valid/ready handshake.
- Reads return shadow RW values or live read-only (RO) values from the accelerator.

---
 rtl/snax_csr_mgr_pkg.sv | 23 ++
 rtl/snax_csr_mgr_if.sv | 43 ++++
 rtl/snax_csr_mgr.sv | 108 ++++++++++
 tb/tb_snax_csr_mgr.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/snax_csr_mgr_pkg.sv
// Shared types and index helpers for the SNAX CSR manager.
// The commit register is the last RW index, and the RO registers are mapped directly after the RW registers.
package snax_csr_mgr_pkg;

    localparam int unsigned DefRegRWCount   = 3;
    localparam int unsigned DefRegROCount   = 2;
    localparam int unsigned DefRegDataWidth = 32;
    localparam int unsigned DefRegAddrWidth = 32;

    typedef enum logic [0:0] {
        IDLE,
        COMMIT
    } state_e;

    function automatic int unsigned commit_idx(input int unsigned rw_count);
        return rw_count - 1;
    endfunction

    function automatic int unsigned ro_base(input int unsigned rw_count);
        return rw_count;
    endfunction

endpackage

// File: rtl/snax_csr_mgr_if.sv
// Interface that bundles the core-side CSR request/response signals with the accelerator register-set signals.
// The slave modport is the manager's view; the master modport is the view of the core and the accelerator.
interface snax_csr_mgr_if
    import snax_csr_mgr_pkg::*;
#(
    parameter int unsigned RegRWCount   = DefRegRWCount,
    parameter int unsigned RegROCount   = DefRegROCount,
    parameter int unsigned RegDataWidth = DefRegDataWidth,
    parameter int unsigned RegAddrWidth = DefRegAddrWidth
) ();

    logic [RegAddrWidth-1:0]                 csr_req_addr_i;
    logic [RegDataWidth-1:0]                 csr_req_data_i;
    logic                                    csr_req_write_i;
    logic                                    csr_req_valid_i;
    logic                                    csr_req_ready_o;
    logic [RegDataWidth-1:0]                 csr_rsp_data_o;
    logic                                    csr_rsp_valid_o;
    logic                                    csr_rsp_ready_i;
    logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_o;
    logic                                    csr_reg_set_valid_o;
    logic                                    csr_reg_set_ready_i;
    logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_i;

    modport slave (
        input  csr_req_addr_i, csr_req_data_i, csr_req_write_i, csr_req_valid_i,
        output csr_req_ready_o,
        output csr_rsp_data_o, csr_rsp_valid_o,
        input  csr_rsp_ready_i,
        output csr_reg_set_o, csr_reg_set_valid_o,
        input  csr_reg_set_ready_i, csr_reg_ro_set_i
    );

    modport master (
        output csr_req_addr_i, csr_req_data_i, csr_req_write_i, csr_req_valid_i,
        input  csr_req_ready_o,
        input  csr_rsp_data_o, csr_rsp_valid_o,
        output csr_rsp_ready_i,
        input  csr_reg_set_o, csr_reg_set_valid_o,
        output csr_reg_set_ready_i, csr_reg_ro_set_i
    );

endinterface

// File: rtl/snax_csr_mgr.sv
// CSR manager: keeps shadow copies of the RW registers and pushes the whole set to the accelerator when the commit index is written.
// Reads return either a shadow value or a live RO value through a one-entry response slot.
module snax_csr_mgr
    import snax_csr_mgr_pkg::*;
#(
    parameter int unsigned RegRWCount   = DefRegRWCount,
    parameter int unsigned RegROCount   = DefRegROCount,
    parameter int unsigned RegDataWidth = DefRegDataWidth,
    parameter int unsigned RegAddrWidth = DefRegAddrWidth
) (
    input logic           clk_i,
    input logic           rst_i,
    snax_csr_mgr_if.slave csr
);

    localparam int unsigned CommitIdx = commit_idx(RegRWCount);
    localparam int unsigned RoBase    = ro_base(RegRWCount);

    state_e                                  state_q, state_d;
    logic [RegRWCount-1:0][RegDataWidth-1:0] shadow_q, shadow_d;
    logic [RegRWCount-1:0][RegDataWidth-1:0] set_q, set_d;
    logic                                    set_valid_q, set_valid_d;
    logic [RegDataWidth-1:0]                 rsp_data_q, rsp_data_d;
    logic                                    rsp_valid_q, rsp_valid_d;
    logic                                    req_ready;
    logic                                    accept;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        set_d       = set_q;
        set_valid_d = set_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;

        req_ready = (state_q == IDLE) && (!rsp_valid_q || csr.csr_rsp_ready_i);
        accept    = csr.csr_req_valid_i && req_ready;

        if (rsp_valid_q && csr.csr_rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept && csr.csr_req_write_i) begin
                    for (int unsigned i = 0; i < RegRWCount; i++) begin
                        if (csr.csr_req_addr_i == RegAddrWidth'(i)) begin
                            shadow_d[i] = csr.csr_req_data_i;
                        end
                    end
                    // The committed set must include the value written in this same cycle.
                    if (csr.csr_req_addr_i == RegAddrWidth'(CommitIdx)) begin
                        set_d       = shadow_d;
                        set_valid_d = 1'b1;
                        state_d     = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (csr.csr_reg_set_ready_i) begin
                    set_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept && !csr.csr_req_write_i) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            for (int unsigned i = 0; i < RegRWCount; i++) begin
                if (csr.csr_req_addr_i == RegAddrWidth'(i)) begin
                    rsp_data_d = shadow_q[i];
                end
            end
            for (int unsigned j = 0; j < RegROCount; j++) begin
                if (csr.csr_req_addr_i == RegAddrWidth'(RoBase + j)) begin
                    rsp_data_d = csr.csr_reg_ro_set_i[j];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            set_q       <= '0;
            set_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            set_q       <= set_d;
            set_valid_q <= set_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign csr.csr_req_ready_o     = req_ready;
    assign csr.csr_rsp_data_o      = rsp_data_q;
    assign csr.csr_rsp_valid_o     = rsp_valid_q;
    assign csr.csr_reg_set_o       = set_q;
    assign csr.csr_reg_set_valid_o = set_valid_q;

endmodule

// File: tb/tb_snax_csr_mgr.sv
// Directed testbench for snax_csr_mgr: covers reads, writes, commit, backpressure, out-of-range access and reset.
// Inputs are driven 1 ns after each rising edge, and registered outputs are sampled at that same point.
module tb_snax_csr_mgr;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    snax_csr_mgr_if #(
        .RegRWCount  (3),
        .RegROCount  (2),
        .RegDataWidth(32),
        .RegAddrWidth(32)
    ) bus ();

    snax_csr_mgr #(
        .RegRWCount  (3),
        .RegROCount  (2),
        .RegDataWidth(32),
        .RegAddrWidth(32)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .csr  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.csr_req_valid_i = v;
        bus.csr_req_write_i = w;
        bus.csr_req_addr_i  = a;
        bus.csr_req_data_i  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        bus.csr_rsp_ready_i     = 1'b1;
        bus.csr_reg_set_ready_i = 1'b1;
        bus.csr_reg_ro_set_i    = '0;
        tick();
        tick();
        checks++; if (bus.csr_reg_set_valid_o !== 1'b0) begin errors++; $display("FAIL rst_set_valid: got %b expected 0", bus.csr_reg_set_valid_o); end
        checks++; if (bus.csr_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.csr_rsp_valid_o); end
        checks++; if (bus.csr_rsp_data_o !== 32'h0) begin errors++; $display("FAIL rst_rsp_data: got %h expected 0", bus.csr_rsp_data_o); end
        checks++; if (bus.csr_reg_set_o !== 96'h0) begin errors++; $display("FAIL rst_set: got %h expected 0", bus.csr_reg_set_o); end
        rst = 1'b0;
        tick();
        checks++; if (bus.csr_req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", bus.csr_req_ready_o); end
    endtask

    task automatic test_read_zero();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'(i), 32'h0);
            tick();
            checks++; if (bus.csr_rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rd0_valid[%0d]: got %b expected 1", i, bus.csr_rsp_valid_o); end
            checks++; if (bus.csr_rsp_data_o !== 32'h0) begin errors++; $display("FAIL rd0_data[%0d]: got %h expected 0", i, bus.csr_rsp_data_o); end
            checks++; if (bus.csr_reg_set_valid_o !== 1'b0) begin errors++; $display("FAIL rd0_set_valid[%0d]: got %b expected 0", i, bus.csr_reg_set_valid_o); end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checks++; if (bus.csr_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rd0_drain: got %b expected 0", bus.csr_rsp_valid_o); end
    endtask

    task automatic test_write_commit();
        logic [2:0][31:0] exp_set;
        exp_set = {32'h1, 32'h10, 32'h2};
        bus.csr_reg_set_ready_i = 1'b1;
        drive(1'b1, 1'b1, 32'd0, 32'h2);
        tick();
        checks++; if (bus.csr_reg_set_valid_o !== 1'b0) begin errors++; $display("FAIL wr0_no_commit: got %b expected 0", bus.csr_reg_set_valid_o); end
        drive(1'b1, 1'b1, 32'd1, 32'h10);
        tick();
        drive(1'b1, 1'b1, 32'd2, 32'h1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus.csr_reg_set_valid_o !== 1'b1) begin errors++; $display("FAIL commit_valid: got %b expected 1", bus.csr_reg_set_valid_o); end
        checks++; if (bus.csr_reg_set_o !== exp_set) begin errors++; $display("FAIL commit_set: got %h expected %h", bus.csr_reg_set_o, exp_set); end
        checks++; if (bus.csr_req_ready_o !== 1'b0) begin errors++; $display("FAIL commit_req_ready: got %b expected 0", bus.csr_req_ready_o); end
        tick();
        checks++; if (bus.csr_reg_set_valid_o !== 1'b0) begin errors++; $display("FAIL commit_pulse_end: got %b expected 0", bus.csr_reg_set_valid_o); end
        checks++; if (bus.csr_req_ready_o !== 1'b1) begin errors++; $display("FAIL commit_ready_back: got %b expected 1", bus.csr_req_ready_o); end
    endtask

    task automatic test_commit_stall();
        logic [2:0][31:0] exp_set;
        exp_set = {32'h5, 32'h10, 32'h2};
        bus.csr_reg_set_ready_i = 1'b0;
        drive(1'b1, 1'b1, 32'd2, 32'h5);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.csr_reg_set_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, bus.csr_reg_set_valid_o); end
            checks++; if (bus.csr_reg_set_o !== exp_set) begin errors++; $display("FAIL stall_set[%0d]: got %h expected %h", k, bus.csr_reg_set_o, exp_set); end
            checks++; if (bus.csr_req_ready_o !== 1'b0) begin errors++; $display("FAIL stall_req_ready[%0d]: got %b expected 0", k, bus.csr_req_ready_o); end
            checks++; if (bus.csr_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL stall_no_accept[%0d]: got %b expected 0", k, bus.csr_rsp_valid_o); end
            tick();
        end
        bus.csr_reg_set_ready_i = 1'b1;
        #1;
        checks++; if (bus.csr_reg_set_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid_6: got %b expected 1", bus.csr_reg_set_valid_o); end
        checks++; if (bus.csr_req_ready_o !== 1'b0) begin errors++; $display("FAIL stall_hs_ready: got %b expected 0", bus.csr_req_ready_o); end
        tick();
        checks++; if (bus.csr_reg_set_valid_o !== 1'b0) begin errors++; $display("FAIL stall_valid_drop: got %b expected 0", bus.csr_reg_set_valid_o); end
        checks++; if (bus.csr_req_ready_o !== 1'b1) begin errors++; $display("FAIL stall_ready_back: got %b expected 1", bus.csr_req_ready_o); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus.csr_rsp_valid_o !== 1'b1) begin errors++; $display("FAIL stall_rd_valid: got %b expected 1", bus.csr_rsp_valid_o); end
        checks++; if (bus.csr_rsp_data_o !== 32'h2) begin errors++; $display("FAIL stall_rd_data: got %h expected 2", bus.csr_rsp_data_o); end
        tick();
    endtask

    task automatic test_ro_read();
        bus.csr_reg_ro_set_i = {32'h7, 32'h1};
        bus.csr_rsp_ready_i  = 1'b1;
        drive(1'b1, 1'b0, 32'd3, 32'h0);
        tick();
        checks++; if (bus.csr_rsp_data_o !== 32'h1) begin errors++; $display("FAIL ro3_data: got %h expected 1", bus.csr_rsp_data_o); end
        checks++; if (bus.csr_req_ready_o !== 1'b1) begin errors++; $display("FAIL ro_b2b_ready: got %b expected 1", bus.csr_req_ready_o); end
        drive(1'b1, 1'b0, 32'd4, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus.csr_rsp_valid_o !== 1'b1) begin errors++; $display("FAIL ro4_valid: got %b expected 1", bus.csr_rsp_valid_o); end
        checks++; if (bus.csr_rsp_data_o !== 32'h7) begin errors++; $display("FAIL ro4_data: got %h expected 7", bus.csr_rsp_data_o); end
        tick();
        checks++; if (bus.csr_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL ro_drain: got %b expected 0", bus.csr_rsp_valid_o); end
    endtask

    task automatic test_backpressure();
        bus.csr_rsp_ready_i = 1'b0;
        drive(1'b1, 1'b0, 32'd0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            checks++; if (bus.csr_rsp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, bus.csr_rsp_valid_o); end
            checks++; if (bus.csr_rsp_data_o !== 32'h2) begin errors++; $display("FAIL bp_data[%0d]: got %h expected 2", k, bus.csr_rsp_data_o); end
            checks++; if (bus.csr_req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", k, bus.csr_req_ready_o); end
            tick();
        end
        bus.csr_rsp_ready_i = 1'b1;
        #1;
        checks++; if (bus.csr_req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.csr_req_ready_o); end
        tick();
        checks++; if (bus.csr_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", bus.csr_rsp_valid_o); end
        tick();
        checks++; if (bus.csr_rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_no_dup2: got %b expected 0", bus.csr_rsp_valid_o); end
    endtask

    task automatic test_read_after_write();
        drive(1'b1, 1'b1, 32'd1, 32'hABCD);
        tick();
        drive(1'b1, 1'b0, 32'd1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus.csr_rsp_data_o !== 32'hABCD) begin errors++; $display("FAIL raw_data: got %h expected abcd", bus.csr_rsp_data_o); end
        tick();
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp_sh [3];
        exp_sh = '{32'h2, 32'hABCD, 32'h5};
        drive(1'b1, 1'b1, 32'd9, 32'hFFFF);
        tick();
        drive(1'b1, 1'b1, 32'h8000_0000, 32'hDEAD);
        tick();
        checks++; if (bus.csr_reg_set_valid_o !== 1'b0) begin errors++; $display("FAIL oor_no_commit: got %b expected 0", bus.csr_reg_set_valid_o); end
        drive(1'b1, 1'b0, 32'd9, 32'h0);
        tick();
        checks++; if (bus.csr_rsp_valid_o !== 1'b1) begin errors++; $display("FAIL oor_rd_valid: got %b expected 1", bus.csr_rsp_valid_o); end
        checks++; if (bus.csr_rsp_data_o !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h expected 0", bus.csr_rsp_data_o); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'(i), 32'h0);
            tick();
            checks++; if (bus.csr_rsp_data_o !== exp_sh[i]) begin errors++; $display("FAIL oor_shadow[%0d]: got %h expected %h", i, bus.csr_rsp_data_o, exp_sh[i]); end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid_commit();
        bus.csr_reg_set_ready_i = 1'b0;
        drive(1'b1, 1'b1, 32'd2, 32'h9);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus.csr_reg_set_valid_o !== 1'b1) begin errors++; $display("FAIL rmc_pre_valid: got %b expected 1", bus.csr_reg_set_valid_o); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.csr_reg_set_valid_o !== 1'b0) begin errors++; $display("FAIL rmc_async_valid: got %b expected 0", bus.csr_reg_set_valid_o); end
        checks++; if (bus.csr_reg_set_o !== 96'h0) begin errors++; $display("FAIL rmc_async_set: got %h expected 0", bus.csr_reg_set_o); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.csr_req_ready_o !== 1'b1) begin errors++; $display("FAIL rmc_ready: got %b expected 1", bus.csr_req_ready_o); end
        drive(1'b1, 1'b0, 32'd0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus.csr_rsp_data_o !== 32'h0) begin errors++; $display("FAIL rmc_shadow_clr: got %h expected 0", bus.csr_rsp_data_o); end
        checks++; if (bus.csr_reg_set_valid_o !== 1'b0) begin errors++; $display("FAIL rmc_no_commit: got %b expected 0", bus.csr_reg_set_valid_o); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_read_zero();
        test_write_commit();
        test_commit_stall();
        test_ro_read();
        test_backpressure();
        test_read_after_write();
        test_out_of_range();
        test_reset_mid_commit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
